// File: rtl/alu_op_decoder_if.sv
// Interface bundling the fetch-side and execute-side handshakes of alu_op_decoder.
// Signal names keep the decoder's own _i/_o suffixes so both ends read the same.
// Optional macro ALU_DEC_ILLEGAL_EN adds the illegal_o flag to the decoded bundle.
interface alu_op_decoder_if #(
  parameter int XLEN = 32
);
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;

  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [4:0]      alu_op_o;
  logic [XLEN-1:0] imm_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic            use_imm_o;
  logic            use_pc_o;
  logic            reg_we_o;
  logic            is_branch_o;
  logic            is_jump_o;
  logic            is_load_o;
  logic            is_store_o;
  logic [XLEN-1:0] pc_o;
`ifdef ALU_DEC_ILLEGAL_EN
  logic            illegal_o;
`endif

  // Fetch and execute stages together: they drive instructions and accept bundles.
  modport master (
    output instr_valid_i, instr_i, pc_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, alu_op_o, imm_o, rs1_o, rs2_o, rd_o,
           use_imm_o, use_pc_o, reg_we_o, is_branch_o, is_jump_o, is_load_o,
           is_store_o, pc_o
`ifdef ALU_DEC_ILLEGAL_EN
    , input illegal_o
`endif
  );

  // Decoder view.
  modport slave (
    input  instr_valid_i, instr_i, pc_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, alu_op_o, imm_o, rs1_o, rs2_o, rd_o,
           use_imm_o, use_pc_o, reg_we_o, is_branch_o, is_jump_o, is_load_o,
           is_store_o, pc_o
`ifdef ALU_DEC_ILLEGAL_EN
    , output illegal_o
`endif
  );
endinterface

// File: rtl/alu_op_decoder.sv
// RV32I decode stage: turns instruction words into ALU operation bundles held in a
// two-entry skid buffer in front of execute. Optional macro ALU_DEC_ILLEGAL_EN makes
// illegal instructions travel as flagged bundles instead of being turned into NOPs.
module alu_op_decoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  alu_op_decoder_if.slave    bus
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [4:0] AluAdd    = 5'b00000;
  localparam logic [4:0] AluJump   = 5'b11111;
  localparam logic [6:0] Funct7Alt = 7'b0100000;

  localparam logic [1:0] FullCount = 2'(DEPTH);

  typedef struct packed {
    logic [4:0]      aluOp;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            useImm;
    logic            usePc;
    logic            regWe;
    logic            isBranch;
    logic            isJump;
    logic            isLoad;
    logic            isStore;
`ifdef ALU_DEC_ILLEGAL_EN
    logic            illegal;
`endif
    logic [XLEN-1:0] pc;
  } bundle_t;

  // Sign-extend a 32-bit immediate (bit 31 is the sign) to the datapath width.
  function automatic logic [XLEN-1:0] extend(input logic [31:0] value);
    return {{(XLEN-31){value[31]}}, value[30:0]};
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immB;
  logic [31:0] immU;
  logic [31:0] immJ;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];
  assign immI   = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
  assign immS   = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
  assign immB   = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                   bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
  assign immU   = {bus.instr_i[31:12], 12'b0};
  assign immJ   = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                   bus.instr_i[20], bus.instr_i[30:21], 1'b0};

  bundle_t decoded;
  logic    isIllegal;

  // Decode the incoming instruction word into a bundle; illegal words are neutralised at the end.
  always_comb begin
    decoded     = '0;
    isIllegal   = 1'b0;
    decoded.rs1 = bus.instr_i[19:15];
    decoded.rs2 = bus.instr_i[24:20];
    decoded.rd  = bus.instr_i[11:7];
    decoded.pc  = bus.pc_i;

    unique case (opcode)
      OpcOp: begin
        decoded.regWe = 1'b1;
        decoded.aluOp = {1'b0, funct7[5], funct3};
        if (funct7 == Funct7Alt) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) isIllegal = 1'b1;
        end else if (funct7 != 7'b0) begin
          isIllegal = 1'b1;
        end
      end
      OpcOpImm: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.imm    = extend(immI);
        decoded.aluOp  = {2'b00, funct3};
        if (funct3 == 3'b001) begin
          if (funct7 != 7'b0) isIllegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == Funct7Alt) decoded.aluOp = {2'b01, funct3};
          else if (funct7 != 7'b0) isIllegal = 1'b1;
        end
      end
      OpcLoad: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.isLoad = 1'b1;
        decoded.imm    = extend(immI);
        decoded.aluOp  = AluAdd;
      end
      OpcStore: begin
        decoded.useImm  = 1'b1;
        decoded.isStore = 1'b1;
        decoded.imm     = extend(immS);
        decoded.aluOp   = AluAdd;
      end
      OpcBranch: begin
        decoded.isBranch = 1'b1;
        decoded.imm      = extend(immB);
        decoded.aluOp    = {2'b10, funct3};
        if (funct3[2:1] == 2'b01) isIllegal = 1'b1;
      end
      OpcLui: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.rs1    = 5'd0;
        decoded.imm    = extend(immU);
        decoded.aluOp  = AluAdd;
      end
      OpcAuipc: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.usePc  = 1'b1;
        decoded.imm    = extend(immU);
        decoded.aluOp  = AluAdd;
      end
      OpcJal: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.usePc  = 1'b1;
        decoded.isJump = 1'b1;
        decoded.imm    = extend(immJ);
        decoded.aluOp  = AluJump;
      end
      OpcJalr: begin
        decoded.regWe  = 1'b1;
        decoded.useImm = 1'b1;
        decoded.isJump = 1'b1;
        decoded.imm    = extend(immI);
        decoded.aluOp  = AluJump;
        if (funct3 != 3'b000) isIllegal = 1'b1;
      end
      default: isIllegal = 1'b1;
    endcase

    if (decoded.rd == 5'd0) decoded.regWe = 1'b0;

    if (isIllegal) begin
`ifdef ALU_DEC_ILLEGAL_EN
      decoded         = '0;
      decoded.rs1     = bus.instr_i[19:15];
      decoded.rs2     = bus.instr_i[24:20];
      decoded.rd      = bus.instr_i[11:7];
      decoded.pc      = bus.pc_i;
      decoded.illegal = 1'b1;
`else
      decoded    = '0;
      decoded.pc = bus.pc_i;
`endif
    end
  end

  logic [1:0] count_q, count_d;
  logic       ready_q, ready_d;
  bundle_t    slot0_q, slot0_d;
  bundle_t    slot1_q, slot1_d;
  logic       push;
  logic       pop;

  assign push = bus.instr_valid_i && ready_q;
  assign pop  = (count_q != 2'd0) && bus.dec_ready_i;

  // Skid-buffer next state: slot0 is always the oldest entry, flush empties everything.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop && count_q == 2'd2) slot0_d = slot1_q;
      if (push) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) slot0_d = decoded;
        else slot1_d = decoded;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    ready_d = (count_d < FullCount);
  end

  // Buffer registers; ready is registered so execute's ready never reaches fetch combinationally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign bus.instr_ready_o = ready_q;
  assign bus.dec_valid_o   = (count_q != 2'd0);
  assign bus.alu_op_o      = slot0_q.aluOp;
  assign bus.imm_o         = slot0_q.imm;
  assign bus.rs1_o         = slot0_q.rs1;
  assign bus.rs2_o         = slot0_q.rs2;
  assign bus.rd_o          = slot0_q.rd;
  assign bus.use_imm_o     = slot0_q.useImm;
  assign bus.use_pc_o      = slot0_q.usePc;
  assign bus.reg_we_o      = slot0_q.regWe;
  assign bus.is_branch_o   = slot0_q.isBranch;
  assign bus.is_jump_o     = slot0_q.isJump;
  assign bus.is_load_o     = slot0_q.isLoad;
  assign bus.is_store_o    = slot0_q.isStore;
  assign bus.pc_o          = slot0_q.pc;
`ifdef ALU_DEC_ILLEGAL_EN
  assign bus.illegal_o     = slot0_q.illegal;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Testbench for alu_op_decoder: directed scenarios plus randomized traffic checked
// against a queue-based reference model. Honors ALU_DEC_ILLEGAL_EN like the design.
module tb_alu_op_decoder;

  logic clk;
  logic rstN;
  logic flush;

  alu_op_decoder_if #(.XLEN(32)) bus ();

  alu_op_decoder #(.XLEN(32), .DEPTH(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  aluOp;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        useImm;
    logic        usePc;
    logic        regWe;
    logic        isBranch;
    logic        isJump;
    logic        isLoad;
    logic        isStore;
    logic        illegal;
    logic [31:0] pc;
  } expT;

  expT modelQ[$];
  int  checkCount = 0;
  int  errorCount = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference decoder written from the ISA rules, using arithmetic shifts for immediates.
  function automatic expT refDecode(input logic [31:0] w, input logic [31:0] pc);
    expT         e;
    bit          bad;
    int          f3;
    logic [6:0]  f7;
    logic [31:0] immI, immS, immB, immU, immJ;
    e    = '0;
    bad  = 0;
    f3   = int'(w[14:12]);
    f7   = w[31:25];
    immI = 32'($signed(w) >>> 20);
    immS = (immI & ~32'h1F) | 32'(w[11:7]);
    immB = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    immU = w & 32'hFFFF_F000;
    immJ = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    e.pc  = pc;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    case (w[6:0])
      7'h33: begin
        e.regWe = 1;
        if (f7 == 7'h00) e.aluOp = 5'(f3);
        else if (f7 == 7'h20 && f3 == 0) e.aluOp = 5'd8;
        else if (f7 == 7'h20 && f3 == 5) e.aluOp = 5'd13;
        else bad = 1;
      end
      7'h13: begin
        e.regWe = 1; e.useImm = 1; e.imm = immI; e.aluOp = 5'(f3);
        if (f3 == 1 && f7 != 7'h00) bad = 1;
        if (f3 == 5) begin
          if (f7 == 7'h20) e.aluOp = 5'd13;
          else if (f7 != 7'h00) bad = 1;
        end
      end
      7'h03: begin e.regWe = 1; e.useImm = 1; e.isLoad = 1; e.imm = immI; end
      7'h23: begin e.useImm = 1; e.isStore = 1; e.imm = immS; end
      7'h63: begin
        e.isBranch = 1; e.imm = immB; e.aluOp = 5'(16 + f3);
        if (f3 == 2 || f3 == 3) bad = 1;
      end
      7'h37: begin e.regWe = 1; e.useImm = 1; e.rs1 = 0; e.imm = immU; end
      7'h17: begin e.regWe = 1; e.useImm = 1; e.usePc = 1; e.imm = immU; end
      7'h6F: begin e.regWe = 1; e.useImm = 1; e.usePc = 1; e.isJump = 1; e.imm = immJ; e.aluOp = 5'd31; end
      7'h67: begin
        e.regWe = 1; e.useImm = 1; e.isJump = 1; e.imm = immI; e.aluOp = 5'd31;
        if (f3 != 0) bad = 1;
      end
      default: bad = 1;
    endcase
    if (e.rd == 0) e.regWe = 0;
    if (bad) begin
`ifdef ALU_DEC_ILLEGAL_EN
      e = '{aluOp: 5'd0, imm: 32'd0, rs1: w[19:15], rs2: w[24:20], rd: w[11:7],
            useImm: 1'b0, usePc: 1'b0, regWe: 1'b0, isBranch: 1'b0, isJump: 1'b0,
            isLoad: 1'b0, isStore: 1'b0, illegal: 1'b1, pc: pc};
`else
      e    = '0;
      e.pc = pc;
`endif
    end
    return e;
  endfunction

  function automatic expT observedBundle();
    expT o;
    o.aluOp    = bus.alu_op_o;
    o.imm      = bus.imm_o;
    o.rs1      = bus.rs1_o;
    o.rs2      = bus.rs2_o;
    o.rd       = bus.rd_o;
    o.useImm   = bus.use_imm_o;
    o.usePc    = bus.use_pc_o;
    o.regWe    = bus.reg_we_o;
    o.isBranch = bus.is_branch_o;
    o.isJump   = bus.is_jump_o;
    o.isLoad   = bus.is_load_o;
    o.isStore  = bus.is_store_o;
`ifdef ALU_DEC_ILLEGAL_EN
    o.illegal  = bus.illegal_o;
`else
    o.illegal  = 1'b0;
`endif
    o.pc       = bus.pc_o;
    return o;
  endfunction

  task automatic compareState(input string tag);
    checkOutput({tag, ".valid"}, 128'(bus.dec_valid_o), 128'(modelQ.size() != 0));
    checkOutput({tag, ".ready"}, 128'(bus.instr_ready_o), 128'(modelQ.size() < 2));
    if (modelQ.size() != 0)
      checkOutput({tag, ".bundle"}, 128'(observedBundle()), 128'(modelQ[0]));
  endtask

  // One clock of traffic: drive inputs, advance the model, then compare just after the edge.
  task automatic applyStimulus(input bit valid, input logic [31:0] instr, input logic [31:0] pc,
                               input bit ready, input bit doFlush, input string tag);
    bit push, pop;
    bus.instr_valid_i = valid;
    bus.instr_i       = instr;
    bus.pc_i          = pc;
    bus.dec_ready_i   = ready;
    flush             = doFlush;
    push = valid && (modelQ.size() < 2);
    pop  = ready && (modelQ.size() > 0);
    @(posedge clk);
    #1;
    if (doFlush) modelQ.delete();
    else begin
      if (pop) modelQ.delete(0);
      if (push) modelQ.push_back(refDecode(instr, pc));
    end
    compareState(tag);
  endtask

  task automatic doReset();
    rstN              = 1'b0;
    flush             = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = 32'h0;
    bus.pc_i          = 32'h0;
    bus.dec_ready_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelQ.delete();
    checkOutput("reset.valid", 128'(bus.dec_valid_o), 128'(0));
    checkOutput("reset.ready", 128'(bus.instr_ready_o), 128'(1));
    checkOutput("reset.bundle", 128'(observedBundle()), 128'(0));
    rstN = 1'b1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int          pick;
    w    = $urandom;
    pick = $urandom_range(0, 10);
    case (pick)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h33;
      default: ;
    endcase
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
    return w;
  endfunction

  initial begin
    rstN = 1'b0;
    doReset();

    // add x3,x1,x2
    applyStimulus(1, 32'h002081B3, 32'h0000_0100, 1, 0, "add");
    checkOutput("add.aluOp", 128'(bus.alu_op_o), 128'(5'b00000));
    checkOutput("add.rs1", 128'(bus.rs1_o), 128'(1));
    checkOutput("add.rs2", 128'(bus.rs2_o), 128'(2));
    checkOutput("add.rd", 128'(bus.rd_o), 128'(3));
    checkOutput("add.regWe", 128'(bus.reg_we_o), 128'(1));
    checkOutput("add.useImm", 128'(bus.use_imm_o), 128'(0));

    // sub, then srai x5,x6,3, then beq x1,x2,+8
    applyStimulus(1, 32'h402081B3, 32'h0000_0104, 1, 0, "sub");
    checkOutput("sub.aluOp", 128'(bus.alu_op_o), 128'(5'b01000));
    applyStimulus(1, 32'h40335293, 32'h0000_0108, 1, 0, "srai");
    checkOutput("srai.aluOp", 128'(bus.alu_op_o), 128'(5'b01101));
    checkOutput("srai.imm", 128'(bus.imm_o), 128'(32'h0000_0403));
    checkOutput("srai.useImm", 128'(bus.use_imm_o), 128'(1));
    checkOutput("srai.rd", 128'(bus.rd_o), 128'(5));
    applyStimulus(1, 32'h00208463, 32'h0000_010C, 1, 0, "beq");
    checkOutput("beq.aluOp", 128'(bus.alu_op_o), 128'(5'b10000));
    checkOutput("beq.imm", 128'(bus.imm_o), 128'(32'h0000_0008));
    checkOutput("beq.isBranch", 128'(bus.is_branch_o), 128'(1));
    checkOutput("beq.regWe", 128'(bus.reg_we_o), 128'(0));
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "drain0");

    // Backpressure: three back-to-back pushes, only two fit.
    applyStimulus(1, 32'h002081B3, 32'h0000_0200, 0, 0, "bp1");
    applyStimulus(1, 32'h40335293, 32'h0000_0204, 0, 0, "bp2");
    checkOutput("bp2.readyLow", 128'(bus.instr_ready_o), 128'(0));
    applyStimulus(1, 32'h00208463, 32'h0000_0208, 0, 0, "bp3");
    checkOutput("bp3.holdPc", 128'(bus.pc_o), 128'(32'h0000_0200));
    applyStimulus(0, 32'h0, 32'h0, 0, 0, "bpHold");
    checkOutput("bpHold.pc", 128'(bus.pc_o), 128'(32'h0000_0200));
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "bpDrain1");
    checkOutput("bpDrain1.pc", 128'(bus.pc_o), 128'(32'h0000_0204));
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "bpDrain2");
    checkOutput("bpDrain2.valid", 128'(bus.dec_valid_o), 128'(0));

    // Flush while full with an incoming instruction.
    applyStimulus(1, 32'h002081B3, 32'h0000_0300, 0, 0, "fl1");
    applyStimulus(1, 32'h402081B3, 32'h0000_0304, 0, 0, "fl2");
    applyStimulus(1, 32'h00208463, 32'h0000_0308, 0, 1, "flush");
    checkOutput("flush.valid", 128'(bus.dec_valid_o), 128'(0));
    checkOutput("flush.ready", 128'(bus.instr_ready_o), 128'(1));
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "postFlush");

    // Illegal opcode.
    applyStimulus(1, 32'h0000007F, 32'h0000_0400, 1, 0, "illegal");
    checkOutput("illegal.regWe", 128'(bus.reg_we_o), 128'(0));
    checkOutput("illegal.aluOp", 128'(bus.alu_op_o), 128'(0));
`ifdef ALU_DEC_ILLEGAL_EN
    checkOutput("illegal.flag", 128'(bus.illegal_o), 128'(1));
`else
    checkOutput("illegal.rd", 128'(bus.rd_o), 128'(0));
`endif
    applyStimulus(0, 32'h0, 32'h0, 1, 0, "postIllegal");

    // Reset while full drops everything.
    applyStimulus(1, 32'h002081B3, 32'h0000_0500, 0, 0, "rs1");
    applyStimulus(1, 32'h40335293, 32'h0000_0504, 0, 0, "rs2");
    doReset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, "rand");
    end
    repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0, "final");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
